// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  localparam int AW_DEF         = 32;
  localparam int DW_DEF         = 32;
  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;

  // Bits needed to hold values 0..maxval (never less than one).
  function automatic int bits_for(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Memory latency down-counter: loads MEM_LAT-1 at issue, done flags the completion cycle.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic busy,
  output logic done
);

  localparam int CW = bits_for(MEM_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      cnt <= '0;
    else if (load)                  cnt <= CW'(MEM_LAT - 1);
    else if (busy && cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// IF/MEM arbiter for a single-port memory, one access outstanding at a time.
// Optional fetch anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
  end

  arb_state_t state;
  arb_owner_t owner;
  logic       wr_flag;
  logic       tmr_done;
  logic       arb;
  logic       force_if;
  logic       grant_d;
  logic       grant_if;

  // Arbitrate when idle or in the completion cycle, enabling back-to-back issue.
  assign arb      = !reset && (state == IDLE || tmr_done);
  assign grant_d  = arb && d_req && !force_if;
  assign grant_if = arb && if_req && !grant_d;

  assign if_gnt    = grant_if;
  assign d_gnt     = grant_d;
  assign mem_en    = grant_d || grant_if;
  assign mem_we    = grant_d && d_we;
  assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = grant_d ? d_wdata : '0;

  assign if_rvalid = tmr_done && (owner == OWN_IF);
  assign d_rvalid  = tmr_done && (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !wr_flag) ? mem_rdata : '0;

  mem_arb_timer #(.MEM_LAT(MEM_LAT)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (mem_en),
    .busy  (state == WAIT),
    .done  (tmr_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_IF;
      wr_flag <= 1'b0;
    end else if (arb) begin
      if (mem_en) begin
        state   <= WAIT;
        owner   <= grant_d ? OWN_D : OWN_IF;
        wr_flag <= grant_d && d_we;
      end else begin
        state   <= IDLE;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = bits_for(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  // Data grants issued while a fetch is waiting; at the limit fetch wins once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       starve_cnt <= '0;
    else if (grant_if || !if_req)                    starve_cnt <= '0;
    else if (grant_d && starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
  end

  assign force_if = if_req && (starve_cnt == SW'(STARVE_MAX));
`else
  assign force_if = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a timestamp-based transaction model.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // second instance with single-cycle latency
  logic          l_if_req, l_d_req, l_d_we;
  logic [AW-1:0] l_if_addr, l_d_addr;
  logic [DW-1:0] l_d_wdata;
  logic          l_if_gnt, l_if_rvalid, l_d_gnt, l_d_rvalid, l_mem_en, l_mem_we;
  logic [DW-1:0] l_if_rdata, l_d_rdata, l_mem_wdata, l_mem_rdata;
  logic [AW-1:0] l_mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_lat1 (
    .clock(clock), .reset(reset),
    .if_req(l_if_req), .if_addr(l_if_addr), .if_gnt(l_if_gnt), .if_rvalid(l_if_rvalid),
    .if_rdata(l_if_rdata),
    .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
    .d_gnt(l_d_gnt), .d_rvalid(l_d_rvalid), .d_rdata(l_d_rdata),
    .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_rdata(l_mem_rdata)
  );

  // Power-on memory contents.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (a[7:0] == 8'h01) ? 32'h0000_00ab : (32'hc0de_0000 | {24'h0, a[7:0]});
  endfunction

  // Memory model: written words overlay the power-on image, reads return LAT cycles later.
  logic [DW-1:0] wmem [256];
  bit            wv   [256];
  logic [DW-1:0] dly  [LAT];

  always @(posedge clock) begin
    dly[0] <= mem_en ? (wv[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : init_word(mem_addr)) : 32'hdead_beef;
    for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    if (mem_en && mem_we) begin
      wmem[mem_addr[7:0]] <= mem_wdata;
      wv[mem_addr[7:0]]   <= 1'b1;
    end
  end
  assign mem_rdata = dly[LAT-1];

  logic [DW-1:0] l_dly;
  always @(posedge clock) l_dly <= l_mem_en ? init_word(l_mem_addr) : 32'hdead_beef;
  assign l_mem_rdata = l_dly;

  // Reference model: completions keyed by cycle number, next arbitration cycle, starvation tally.
  typedef struct {
    int            t;
    bit            is_d;
    logic [DW-1:0] data;
  } comp_t;

  comp_t         pend [$];
  logic [DW-1:0] ref_mem [256];
  int            cyc     = 0;
  int            free_at = 0;
  int            starve  = 0;

  logic          o_if_gnt, o_d_gnt, o_mem_we, o_if_rvalid, o_d_rvalid;
  logic [DW-1:0] o_if_rdata, o_d_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: compare at negedge against the model, advance the model, return just after posedge.
  task automatic step();
    bit            rst, allowed, frc, wd, wi, cv, cd;
    logic [DW-1:0] cdata;
    @(negedge clock);
    rst     = reset;
    allowed = !rst && (cyc >= free_at);
    frc     = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    frc     = if_req && (starve >= SMAX);
`endif
    wd = allowed && d_req && !frc;
    wi = allowed && if_req && !wd;
    cv = 1'b0; cd = 1'b0; cdata = '0;
    if (!rst && pend.size() != 0 && pend[0].t == cyc) begin
      cv = 1'b1; cd = pend[0].is_d; cdata = pend[0].data;
      void'(pend.pop_front());
    end

    o_if_gnt = if_gnt;  o_d_gnt = d_gnt;  o_mem_we = mem_we;
    o_if_rvalid = if_rvalid;  o_d_rvalid = d_rvalid;
    o_if_rdata = if_rdata;  o_d_rdata = d_rdata;

    check("ctl", 64'({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid}),
                 64'({wi, wd, wi | wd, wd & d_we, cv & !cd, cv & cd}));
    if (wi || wd) check("mem_addr", 64'(mem_addr), 64'(wd ? d_addr : if_addr));
    if (wd && d_we) check("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
    check("if_rdata", 64'(if_rdata), 64'((cv && !cd) ? cdata : '0));
    check("d_rdata",  64'(d_rdata),  64'((cv && cd) ? cdata : '0));
    if (rst) check("rst_bus", 64'(mem_addr | mem_wdata), 64'(0));

    if (rst) begin
      pend.delete();
      free_at = 0;
      starve  = 0;
    end else begin
      if (wd) begin
        pend.push_back('{cyc + LAT, 1'b1, d_we ? '0 : ref_mem[d_addr[7:0]]});
        if (d_we) ref_mem[d_addr[7:0]] = d_wdata;
        free_at = cyc + LAT;
      end else if (wi) begin
        pend.push_back('{cyc + LAT, 1'b0, ref_mem[if_addr[7:0]]});
        free_at = cyc + LAT;
      end
      if (wd && if_req)      starve++;
      else if (wi || !if_req) starve = 0;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  int nrv, ni, nd;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(AW'(i));
    reset = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    l_if_req = 0; l_if_addr = '0; l_d_req = 0; l_d_we = 0; l_d_addr = '0; l_d_wdata = '0;

    // reset state
    step();
    check("rst_outs", 64'({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid}), 64'(0));
    reset = 1'b0;

    // single fetch
    if_req = 1; if_addr = 32'h10;
    step(); check("f_gnt", 64'(o_if_gnt), 64'(1));
    if_req = 0;
    step(); step();
    check("f_rvalid", 64'(o_if_rvalid), 64'(1));
    check("f_rdata", 64'(o_if_rdata), 64'(32'hc0de_0010));

    // simultaneous data read and fetch
    d_req = 1; d_we = 0; d_addr = 32'h1; if_req = 1; if_addr = 32'h20;
    step();
    check("dp_dgnt", 64'({o_d_gnt, o_if_gnt}), 64'(2'b10));
    d_req = 0;
    step(); step();
    check("dp_drvalid", 64'(o_d_rvalid), 64'(1));
    check("dp_drdata", 64'(o_d_rdata), 64'(32'h0000_00ab));
    check("dp_ifgnt", 64'(o_if_gnt), 64'(1));
    if_req = 0;
    step(); step();
    check("dp_ifrvalid", 64'(o_if_rvalid), 64'(1));
    check("dp_ifrdata", 64'(o_if_rdata), 64'(32'hc0de_0020));

    // write then read back
    d_req = 1; d_we = 1; d_addr = 32'h4; d_wdata = 32'h8000_0000;
    step(); check("wr_memwe", 64'(o_mem_we), 64'(1));
    d_req = 0;
    step(); step();
    check("wr_ack", 64'({o_d_rvalid, o_d_rdata}), 64'({1'b1, 32'h0}));
    d_req = 1; d_we = 0; d_addr = 32'h4;
    step(); d_req = 0;
    step(); step();
    check("wr_readback", 64'(o_d_rdata), 64'(32'h8000_0000));

    // async reset aborts an outstanding read
    d_req = 1; d_we = 0; d_addr = 32'h8;
    step(); d_req = 0;
    #1 reset = 1'b1;
    step(); reset = 1'b0;
    nrv = 0;
    repeat (4) begin step(); nrv += int'(o_if_rvalid) + int'(o_d_rvalid); end
    check("abort_rvalid", 64'(nrv), 64'(0));
    if_req = 1; if_addr = 32'h5;
    step(); check("post_rst_gnt", 64'(o_if_gnt), 64'(1));
    if_req = 0;
    step(); step();

    // both requesters held high
    reset = 1'b1; step(); reset = 1'b0;
    if_req = 1; if_addr = 32'h30; d_req = 1; d_we = 0; d_addr = 32'h40;
    ni = 0; nd = 0;
    repeat (24) begin step(); ni += int'(o_if_gnt); nd += int'(o_d_gnt); end
`ifdef ARB_STARVE_GUARD_EN
    check("starve_if", 64'(ni), 64'(2));
    check("starve_d",  64'(nd), 64'(10));
`else
    check("starve_if", 64'(ni), 64'(0));
    check("starve_d",  64'(nd), 64'(12));
`endif
    if_req = 0; d_req = 0;
    repeat (3) step();

    // random traffic
    repeat (400) begin
      step();
      if (!if_req || o_if_gnt) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom_range(0, 255));
      end
      if (!d_req || o_d_gnt) begin
        d_req   = ($urandom_range(0, 1) != 0);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = AW'($urandom_range(0, 255));
        d_wdata = $urandom;
      end
    end
    if_req = 0; d_req = 0;
    repeat (4) step();

    // MEM_LAT=1 streaming fetch
    l_if_req = 1; l_if_addr = 32'h50;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("l1_gnt", 64'(l_if_gnt), 64'(1));
      if (k == 0) check("l1_first", 64'(l_if_rvalid), 64'(0));
      else begin
        check("l1_rvalid", 64'(l_if_rvalid), 64'(1));
        check("l1_rdata", 64'(l_if_rdata), 64'(init_word(l_if_addr - 1)));
      end
      @(posedge clock);
      #1 l_if_addr = l_if_addr + 1;
    end
    l_if_req = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
